// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory handshake, stall and MEM/WB register
// Loads/stores hold the pipeline in ACCESS until ack or timeout; aborted ops write back a bubble.

module mem_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  wb_i,
   input  logic [2:0]  mem_i,
   input  logic [31:0] result_i,
   input  logic [31:0] rtdata_i,
   input  logic [4:0]  writeaddr_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic [1:0]  wb_o,
   output logic [31:0] rdata_o,
   output logic [31:0] result_o,
   output logic [4:0]  writeaddr_o,
   output logic        err_o
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic        lat_we;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [1:0]  lat_wb;
   logic [4:0]  lat_wa;

   logic memop;
   logic in_access;
   logic wait_expired;
   logic unused_branch;

   assign memop         = mem_i[1] | mem_i[0];
   assign in_access     = (state == ACCESS);
   assign wait_expired  = (cnt >= CNT_LAST);
   assign unused_branch = mem_i[2];

   assign dmem_req_o   = in_access;
   assign dmem_we_o    = in_access & lat_we;
   assign dmem_addr_o  = in_access ? lat_addr  : 32'd0;
   assign dmem_wdata_o = in_access ? lat_wdata : 32'd0;

   // Gated by rst_i so the upstream freeze drops the instant reset is applied.
   always_comb begin
      stall_o = 1'b0;
      if (rst_i) begin
         if (in_access)
            stall_o = !dmem_ack_i && !wait_expired;
         else
            stall_o = memop;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         lat_we      <= 1'b0;
         lat_addr    <= 32'd0;
         lat_wdata   <= 32'd0;
         lat_wb      <= 2'b00;
         lat_wa      <= 5'd0;
         wb_o        <= 2'b00;
         rdata_o     <= 32'd0;
         result_o    <= 32'd0;
         writeaddr_o <= 5'd0;
         err_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (memop) begin
                  lat_we    <= mem_i[0];
                  lat_addr  <= result_i;
                  lat_wdata <= rtdata_i;
                  lat_wb    <= wb_i;
                  lat_wa    <= writeaddr_i;
                  cnt       <= 8'd0;
                  wb_o      <= 2'b00;
                  state     <= ACCESS;
               end else begin
                  wb_o        <= wb_i;
                  result_o    <= result_i;
                  writeaddr_o <= writeaddr_i;
                  rdata_o     <= 32'd0;
               end
            end
            ACCESS: begin
               if (dmem_ack_i) begin
                  wb_o        <= lat_wb;
                  result_o    <= lat_addr;
                  writeaddr_o <= lat_wa;
                  rdata_o     <= lat_we ? 32'd0 : dmem_rdata_i;
                  state       <= IDLE;
               end else if (wait_expired) begin
                  err_o <= 1'b1;
                  wb_o  <= 2'b00;
                  state <= IDLE;
               end else begin
                  cnt  <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                  wb_o <= 2'b00;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage (TIMEOUT=4)

module tb_mem_stage;

   typedef struct packed {
      logic [1:0]  wb;
      logic [31:0] rdata;
      logic [31:0] result;
      logic [4:0]  wa;
   } wb_exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  wb_i;
   logic [2:0]  mem_i;
   logic [31:0] result_i;
   logic [31:0] rtdata_i;
   logic [4:0]  writeaddr_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic        stall_o;
   logic [1:0]  wb_o;
   logic [31:0] rdata_o;
   logic [31:0] result_o;
   logic [4:0]  writeaddr_o;
   logic        err_o;

   int vectors     = 0;
   int miscompares = 0;
   wb_exp_t sb[$];

   mem_stage #(.TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .wb_i(wb_i), .mem_i(mem_i),
      .result_i(result_i), .rtdata_i(rtdata_i), .writeaddr_i(writeaddr_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
      .stall_o(stall_o), .wb_o(wb_o), .rdata_o(rdata_o), .result_o(result_o),
      .writeaddr_o(writeaddr_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [2:0] m, input logic [1:0] w, input logic [31:0] r,
                        input logic [31:0] d, input logic [4:0] a);
      mem_i = m; wb_i = w; result_i = r; rtdata_i = d; writeaddr_i = a;
   endtask

   task automatic pop_check(input string tag);
      wb_exp_t e;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_wb"}, 32'(wb_o), 32'(e.wb));
         chk({tag, "_rdata"}, rdata_o, e.rdata);
         chk({tag, "_result"}, result_o, e.result);
         chk({tag, "_waddr"}, 32'(writeaddr_o), 32'(e.wa));
      end
   endtask

   initial begin
      int stall_cnt;
      logic [3:0] pat;

      rst_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
      drive(3'b010, 2'b11, 32'h40, 32'h1, 5'd3);
      #12;
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_req", 32'(dmem_req_o), 32'd0);
      chk("rst_wb", 32'(wb_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      drive(3'b000, 2'b00, 32'd0, 32'd0, 5'd0);
      @(negedge clk_i); rst_i = 1'b1;
      tick();

      // ALU op, with a stray ack that must be ignored outside ACCESS
      drive(3'b000, 2'b10, 32'h1234, 32'd0, 5'd7);
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
      sb.push_back('{2'b10, 32'd0, 32'h1234, 5'd7});
      #2 chk("alu_stall", 32'(stall_o), 32'd0);
      chk("alu_req", 32'(dmem_req_o), 32'd0);
      tick();
      dmem_ack_i = 1'b0;
      pop_check("alu");

      // Load, three waits then ack on the TIMEOUT-1 boundary cycle
      drive(3'b010, 2'b11, 32'h40, 32'h5555, 5'd3);
      sb.push_back('{2'b11, 32'hDEADBEEF, 32'h40, 5'd3});
      stall_cnt = 0;
      #2 chk("ld_idle_req", 32'(dmem_req_o), 32'd0);
      stall_cnt += int'(stall_o);
      tick();
      chk("ld_bubble", 32'(wb_o), 32'd0);
      result_i = 32'hFFFF_0000;
      for (int i = 0; i < 3; i++) begin
         #2 chk("ld_wait_req", 32'(dmem_req_o), 32'd1);
         chk("ld_wait_addr", dmem_addr_o, 32'h40);
         chk("ld_wait_we", 32'(dmem_we_o), 32'd0);
         stall_cnt += int'(stall_o);
         tick();
         chk("ld_wait_wb", 32'(wb_o), 32'd0);
      end
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF;
      #2 chk("ld_ack_stall", 32'(stall_o), 32'd0);
      chk("ld_ack_addr", dmem_addr_o, 32'h40);
      tick();
      dmem_ack_i = 1'b0;
      drive(3'b000, 2'b00, 32'd0, 32'd0, 5'd0);
      pop_check("ld");
      chk("ld_stall_cycles", 32'(stall_cnt), 32'd4);
      chk("ld_exit_req", 32'(dmem_req_o), 32'd0);

      // Store, immediate ack
      drive(3'b001, 2'b00, 32'h80, 32'hCAFE0001, 5'd5);
      sb.push_back('{2'b00, 32'd0, 32'h80, 5'd5});
      #2 chk("st_idle_stall", 32'(stall_o), 32'd1);
      tick();
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'h0BAD_0BAD;
      #2 chk("st_we", 32'(dmem_we_o), 32'd1);
      chk("st_wdata", dmem_wdata_o, 32'hCAFE0001);
      chk("st_addr", dmem_addr_o, 32'h80);
      chk("st_stall", 32'(stall_o), 32'd0);
      tick();
      dmem_ack_i = 1'b0;
      drive(3'b000, 2'b00, 32'd0, 32'd0, 5'd0);
      pop_check("st");
      chk("st_exit_we", 32'(dmem_we_o), 32'd0);
      chk("st_exit_wdata", dmem_wdata_o, 32'd0);

      // Load with no ack: abort after four ACCESS cycles
      drive(3'b010, 2'b11, 32'h100, 32'd0, 5'd9);
      #2 chk("to_idle_stall", 32'(stall_o), 32'd1);
      tick();
      for (int k = 0; k < 4; k++) begin
         #2 chk("to_req", 32'(dmem_req_o), 32'd1);
         chk("to_stall", 32'(stall_o), (k < 3) ? 32'd1 : 32'd0);
         chk("to_err_pre", 32'(err_o), 32'd0);
         tick();
      end
      chk("to_err", 32'(err_o), 32'd1);
      chk("to_req_off", 32'(dmem_req_o), 32'd0);
      chk("to_wb", 32'(wb_o), 32'd0);
      drive(3'b000, 2'b10, 32'h55, 32'd0, 5'd2);
      sb.push_back('{2'b10, 32'd0, 32'h55, 5'd2});
      #2 chk("to_alu_stall", 32'(stall_o), 32'd0);
      tick();
      pop_check("to_alu");
      chk("to_err_sticky", 32'(err_o), 32'd1);

      // Reset in the second ACCESS cycle; the following ack must be ignored
      drive(3'b010, 2'b11, 32'h200, 32'd0, 5'd1);
      tick();
      #2 chk("rs_req1", 32'(dmem_req_o), 32'd1);
      tick();
      rst_i = 1'b0;
      #1 chk("rs_req", 32'(dmem_req_o), 32'd0);
      chk("rs_stall", 32'(stall_o), 32'd0);
      chk("rs_addr", dmem_addr_o, 32'd0);
      chk("rs_err", 32'(err_o), 32'd0);
      chk("rs_wb", 32'(wb_o), 32'd0);
      chk("rs_result", result_o, 32'd0);
      chk("rs_waddr", 32'(writeaddr_o), 32'd0);
      drive(3'b000, 2'b00, 32'd0, 32'd0, 5'd0);
      @(negedge clk_i); rst_i = 1'b1;
      tick();
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBAD0BAD0;
      #2 chk("rs_ack_req", 32'(dmem_req_o), 32'd0);
      chk("rs_ack_stall", 32'(stall_o), 32'd0);
      tick();
      dmem_ack_i = 1'b0;
      chk("rs_rdata", rdata_o, 32'd0);
      chk("rs_err_after", 32'(err_o), 32'd0);
      chk("rs_req_after", 32'(dmem_req_o), 32'd0);

      // Back-to-back load then store, each acked on its first ACCESS cycle
      pat = 4'd0;
      drive(3'b010, 2'b11, 32'h300, 32'd0, 5'd4);
      sb.push_back('{2'b11, 32'h11112222, 32'h300, 5'd4});
      #2 pat = {pat[2:0], stall_o};
      tick();
      dmem_ack_i = 1'b1; dmem_rdata_i = 32'h11112222;
      #2 pat = {pat[2:0], stall_o};
      tick();
      dmem_ack_i = 1'b0;
      pop_check("bb_ld");
      drive(3'b001, 2'b00, 32'h304, 32'hAAAA5555, 5'd6);
      sb.push_back('{2'b00, 32'd0, 32'h304, 5'd6});
      #2 pat = {pat[2:0], stall_o};
      tick();
      dmem_ack_i = 1'b1;
      #2 pat = {pat[2:0], stall_o};
      chk("bb_st_wdata", dmem_wdata_o, 32'hAAAA5555);
      tick();
      dmem_ack_i = 1'b0;
      drive(3'b000, 2'b00, 32'd0, 32'd0, 5'd0);
      pop_check("bb_st");
      chk("bb_stall_pattern", 32'(pat), 32'b1010);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255, max ACCESS wait cycles without ack before abort (1..255).
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 wb_i  in  2  from EX/MEM: bit1 RegWrite, bit0 MemtoReg.
REQ-005 mem_i  in  3  from EX/MEM: bit2 Branch (ignored here), bit1 MemRead, bit0 MemWrite.
REQ-006 result_i  in  32  ALU result; memory byte address for load/store.
REQ-007 rtdata_i  in  32  store data.
REQ-008 writeaddr_i  in  5  destination register.
REQ-009 dmem_req_o  out  1  data-memory request.
REQ-010 dmem_we_o  out  1  1 = write, 0 = read.
REQ-011 dmem_addr_o  out  32  access address.
REQ-012 dmem_wdata_o  out  32  write data.
REQ-013 dmem_ack_i  in  1  memory completion, one-cycle pulse.
REQ-014 dmem_rdata_i  in  32  read data, valid when dmem_ack_i=1.
REQ-015 stall_o  out  1  freeze EX/MEM and earlier stages (combinational).
REQ-016 wb_o  out  2  MEM/WB registered control to WB.
REQ-017 rdata_o  out  32  MEM/WB registered load data.
REQ-018 result_o  out  32  MEM/WB registered ALU result.
REQ-019 writeaddr_o  out  5  MEM/WB registered destination.
REQ-020 err_o  out  1  sticky memory-timeout flag.

Function
REQ-021 FSM states: IDLE, ACCESS; memop = mem_i[1] | mem_i[0].
REQ-022 IDLE, memop=0: stall_o=0; at edge MEM/WB loads wb_i, result_i, writeaddr_i, rdata_o <= 0; stay IDLE.
REQ-023 IDLE, memop=1: stall_o=1; at edge latch result_i, rtdata_i, wb_i, writeaddr_i, we=mem_i[0] (MemWrite wins if both bits set); MEM/WB loads bubble (wb_o=0, others unchanged); go ACCESS; wait counter <= 0.
REQ-024 ACCESS: dmem_req_o=1; dmem_we_o, dmem_addr_o, dmem_wdata_o = latched values, stable until exit.
REQ-025 ACCESS, dmem_ack_i=1: stall_o=0; at edge MEM/WB loads latched wb, result, writeaddr, rdata_o <= dmem_rdata_i (rdata_o <= 0 for store); go IDLE.
REQ-026 ACCESS, dmem_ack_i=0, counter < TIMEOUT-1: stall_o=1; counter +1; MEM/WB loads bubble.
REQ-027 ACCESS, dmem_ack_i=0, counter = TIMEOUT-1: stall_o=0; err_o <= 1; MEM/WB loads bubble (aborted op never writes back); go IDLE.
REQ-028 Outside ACCESS: dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0; dmem_ack_i ignored.
REQ-029 Inputs ignored in ACCESS; upstream holds them stable via stall_o.
REQ-030 Minimum memop latency: 2 cycles (IDLE cycle + ACCESS with ack); non-memop: 1 cycle.
REQ-031 Back-to-back memops: after ACCESS exit, next IDLE cycle evaluates the new instruction; no dead cycle beyond REQ-023.
REQ-032 Counter 8 bits, saturates, never wraps.
REQ-033 err_o, once set, stays 1 until reset; pipeline continues operating.

Reset
REQ-034 rst_i=0 asynchronously forces IDLE, counter 0, latches 0, wb_o=0, rdata_o=0, result_o=0, writeaddr_o=0, err_o=0; dmem_req_o=0 and stall_o=0 immediately.
REQ-035 Reset during ACCESS abandons the access; a later dmem_ack_i is ignored.
REQ-036 First edge after rst_i rises behaves as IDLE.

Verification
REQ-037 ALU op wb_i=2'b10, result_i=0x1234, writeaddr_i=7, mem_i=0 -> next cycle wb_o=2'b10, result_o=0x1234, writeaddr_o=7, stall_o never 1.
REQ-038 Load mem_i=3'b010, result_i=0x40, wb_i=2'b11, writeaddr_i=3; ack after 3 ACCESS cycles with rdata 0xDEADBEEF -> stall_o high 4 cycles, dmem_addr_o=0x40 stable, then wb_o=2'b11, rdata_o=0xDEADBEEF, writeaddr_o=3.
REQ-039 Store mem_i=3'b001, result_i=0x80, rtdata_i=0xCAFE0001, immediate ack -> dmem_we_o=1, dmem_wdata_o=0xCAFE0001 for 1 cycle, stall_o high 1 cycle, wb_o=0.
REQ-040 TIMEOUT=4, load, no ack -> dmem_req_o high 4 cycles, err_o=1 after 4th, wb_o=0, FSM IDLE, next ALU op completes normally.
REQ-041 Reset asserted in 2nd ACCESS cycle of a load, ack on following cycle -> all outputs 0 immediately, ack ignored, err_o=0.
REQ-042 Load then store back-to-back, each acked at first ACCESS cycle -> 4 cycles total, stall_o pattern 1,0,1,0.
